// File: rtl/serial_addsub_pkg.sv
// rtl/serial_addsub_pkg.sv - shared states and opcode constants for the bit-serial adder/subtractor
package serial_addsub_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/serial_addsub_seq_if.sv
// rtl/serial_addsub_seq_if.sv - request/result bundle of serial_addsub_seq (ovf gated by SERIAL_ADDSUB_OVF_EN)
interface serial_addsub_seq_if #(parameter int W = 8);
  logic         start;
  logic         op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
`ifdef SERIAL_ADDSUB_OVF_EN
  logic         ovf;
  modport master (output start, op, a, b, input busy, done, result, cout, ovf);
  modport slave  (input start, op, a, b, output busy, done, result, cout, ovf);
`else
  modport master (output start, op, a, b, input busy, done, result, cout);
  modport slave  (input start, op, a, b, output busy, done, result, cout);
`endif
endinterface

// File: rtl/addsub_cell.sv
// rtl/addsub_cell.sv - one-bit full adder with B inversion for subtraction
module addsub_cell (
  input  logic i0,
  input  logic i1,
  input  logic addsub,
  input  logic cin,
  output logic sumdiff,
  output logic cout
);
  logic i1_x;

  assign i1_x    = i1 ^ addsub;
  assign sumdiff = i0 ^ i1_x ^ cin;
  assign cout    = (i0 & i1_x) | (i0 & cin) | (i1_x & cin);
endmodule

// File: rtl/serial_addsub_seq_shreg_rl.sv
// rtl/serial_addsub_seq_shreg_rl.sv - W-bit right-shift register, parallel load, serial-in at MSB
module shreg_rl #(parameter int W = 8) (
  input  logic         clk,
  input  logic         reset_,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         shift_i,
  input  logic         sin_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] sr_q;
  logic [W-1:0] sr_d;

  // load wins over shift so an accept never mixes with a stale shift
  always_comb begin
    sr_d = sr_q;
    if (load_i)       sr_d = load_val_i;
    else if (shift_i) sr_d = {sin_i, sr_q[W-1:1]};
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) sr_q <= '0;
    else         sr_q <= sr_d;
  end

  assign q_o = sr_q;
endmodule

// File: rtl/serial_addsub_seq.sv
// rtl/serial_addsub_seq.sv - bit-serial W-bit add/sub sequencer, LSB first (optional ovf: SERIAL_ADDSUB_OVF_EN)
module serial_addsub_seq
  import serial_addsub_pkg::*;
#(
  parameter int W = 8
) (
  input logic                 clk,
  input logic                 reset_,
  serial_addsub_seq_if.slave  bus
);
  localparam int CW = $clog2(W);

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          carry_q, carry_d;
  logic          op_q, op_d;
  logic          accept, run, last;
  logic [W-1:0]  a_sr, b_sr;
  logic          cell_sum, cell_cout;
  logic          unused_b;

  assign run    = (state_q == RUN);
  assign accept = (state_q != RUN) && bus.start;
  assign last   = run && (count_q == CW'(W - 1));

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    carry_d = carry_q;
    op_d    = op_q;
    case (state_q)
      IDLE: if (bus.start) state_d = RUN;
      RUN:  if (last)      state_d = DONE;
      DONE: state_d = bus.start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
    // subtraction is a + ~b + 1, so the initial carry equals the opcode
    if (accept) begin
      count_d = '0;
      carry_d = bus.op;
      op_d    = bus.op;
    end else if (run) begin
      count_d = count_q + 1'b1;
      carry_d = cell_cout;
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q <= IDLE;
      count_q <= '0;
      carry_q <= 1'b0;
      op_q    <= OP_ADD;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      carry_q <= carry_d;
      op_q    <= op_d;
    end
  end

  shreg_rl #(.W(W)) u_a_sr (
    .clk(clk), .reset_(reset_), .load_i(accept), .load_val_i(bus.a),
    .shift_i(run), .sin_i(cell_sum), .q_o(a_sr)
  );

  shreg_rl #(.W(W)) u_b_sr (
    .clk(clk), .reset_(reset_), .load_i(accept), .load_val_i(bus.b),
    .shift_i(run), .sin_i(1'b0), .q_o(b_sr)
  );

  addsub_cell u_cell (
    .i0(a_sr[0]), .i1(b_sr[0]), .addsub(op_q), .cin(carry_q),
    .sumdiff(cell_sum), .cout(cell_cout)
  );

  assign unused_b   = ^b_sr[W-1:1];
  assign bus.busy   = run;
  assign bus.done   = (state_q == DONE);
  assign bus.result = a_sr;
  assign bus.cout   = carry_q;

`ifdef SERIAL_ADDSUB_OVF_EN
  logic cmsb_q;

  // carry into the MSB is the carry register on the last bit cycle
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_)   cmsb_q <= 1'b0;
    else if (last) cmsb_q <= carry_q;
  end

  assign bus.ovf = cmsb_q ^ carry_q;
`endif
endmodule
